tail_lamp_sequencer: RTL and testbench
======================================

// Module: tail_lamp_sequencer
// PURPOSE
//  Parametrised sequential tail-lamp controller: N lamps per side, left/right sweep,
//  hazard flash and brake override. Step rate comes from an internal clock prescaler.
//  Sits between the indicator-stalk/brake inputs and the lamp drivers.
// PARAMETERS
//  N_LAMPS   3  lamps per side (>=1); bit 0 = innermost lamp
//  TICK_DIV  4  clk cycles per animation step (>=1); 1 = step every cycle
// PORTS
//  clk      in   1        single clock, rising edge
//  reset    in   1        asynchronous, active-high; clears all state and outputs
//  left     in   1        left-turn request (level)
//  right    in   1        right-turn request (level)
//  hazard   in   1        hazard request (level)
//  brake    in   1        brake pedal (level)
//  lamps_l  out  N_LAMPS  left lamp drive, 1 = lit
//  lamps_r  out  N_LAMPS  right lamp drive, 1 = lit
//  busy     out  1        1 while state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, step=0, phase=OFF, div_cnt=0, brake_q=0; lamps_l=lamps_r=0, busy=0.
//  Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps; free-running from reset release.
//   tick=1 when div_cnt==TICK_DIV-1. All state/step/phase changes happen only on tick.
//  brake_q: brake registered every clk (not tick-gated). No combinational input->output path.
//  States: IDLE, LEFT, RIGHT, HAZARD. step: 0..N_LAMPS. phase: OFF/ON (HAZARD only).
//  IDLE on tick, priority: hazard | (left&right) -> HAZARD, phase=ON;
//   else left -> LEFT, step=1; else right -> RIGHT, step=1; else stay IDLE.
//  LEFT/RIGHT on tick: hazard -> HAZARD, phase=ON, step=0 (preempts sweep);
//   else step<N_LAMPS -> step+1; step==N_LAMPS -> IDLE, step=0.
//   left/right changes mid-sweep are ignored; a held request restarts a sweep after 1 IDLE step.
//  HAZARD on tick: phase==ON and !hazard -> IDLE; else phase toggles.
//   Exit only from ON phase, so the last visible frame is always full-on; next is off.
//  Output decode (from registered state, step, phase, brake_q):
//   LEFT:   lamps_l = thermometer(step) = (1<<step)-1 (inner lamps first); lamps_r = {N{brake_q}}
//   RIGHT:  lamps_r = thermometer(step); lamps_l = {N{brake_q}}
//   HAZARD: both sides = {N{phase==ON}}; brake ignored
//   IDLE:   both sides = {N{brake_q}}
//  Latency: request held at tick edge -> first lamp lit right after that edge (0 extra cycles).
//   brake -> lamps: 1 clk. Full sweep = N_LAMPS ticks lit + 1 tick dark.
//  Reset mid-operation: immediate (async) return to reset values; prescaler restarts at 0.
//  Widths: div_cnt = $clog2(TICK_DIV) bits (min 1); step = $clog2(N_LAMPS+1) bits.
//   Thermometer built without overflow for any N_LAMPS (no 1<<N in an N-bit expression).
// STRUCTURE
//  Shared package tail_lamp_pkg: state encoding IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2,
//   HAZARD=2'd3; PHASE_OFF/PHASE_ON constants.
//  Sub-module tick_prescaler (TICK_DIV param; clk, reset -> tick). Rest is one FSM +
//   step counter + output decode in this module.
// TESTING (N_LAMPS=3, TICK_DIV=4 unless stated)
//  1 Left sweep: left=1 for one tick -> lamps_l 001,011,111,000 on consecutive ticks;
//    lamps_r=000; busy high 3 ticks.
//  2 Right sweep with brake=1: lamps_r 001,011,111; lamps_l=111 throughout;
//    after sweep both 111.
//  3 Hazard preempt: start left, at lamps_l=011 raise hazard -> next tick both 111,
//    then 000/111 alternating; drop hazard during OFF -> one more 111, then IDLE 000.
//  4 left&right together in IDLE -> HAZARD (both sides 111 first tick).
//  5 Async reset mid-sweep (lamps_l=011, between clk edges) -> outputs 000, busy=0
//    immediately; first tick 4 clks after release.
//  6 Params N_LAMPS=1, TICK_DIV=1: held left -> lamps_l 1,0,1,0 each clk;
//    N_LAMPS=8: sweep reaches 8'hFF.

Source files
------------

// File: rtl/tail_lamp_pkg.sv
// Shared encodings for the tail-lamp sequencer: FSM state and hazard flash phase.
package tail_lamp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  localparam logic PHASE_OFF = 1'b0;
  localparam logic PHASE_ON  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one clk every TICK_DIV clks, first at cycle TICK_DIV-1.
// Latency: counter restarts at 0 on reset; no backpressure, runs unconditionally.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == CNT_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign tick = (r_div_cnt == CNT_LAST);

endmodule

// File: rtl/tail_lamp_sequencer.sv
// Sequential tail-lamp controller: left/right inner-to-outer sweep, hazard flash, brake override.
// Latency: request seen at a tick edge lights its first lamp at that edge; brake shows after 1 clk.
module tail_lamp_sequencer #(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  input  logic               brake,
  output logic [N_LAMPS-1:0] lamps_l,
  output logic [N_LAMPS-1:0] lamps_r,
  output logic               busy
);
  import tail_lamp_pkg::*;

  localparam int SW = $clog2(N_LAMPS + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(N_LAMPS);
  localparam logic [SW-1:0] STEP_ONE = SW'(1);

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_step, w_step_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_brake_q;
  logic              w_tick;
  logic [N_LAMPS-1:0] w_therm;
  logic [N_LAMPS-1:0] w_brk_vec;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_phase   <= PHASE_OFF;
      r_brake_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_phase   <= w_phase_nxt;
      r_brake_q <= brake;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_phase_nxt = r_phase;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (hazard || (left && right)) begin
            w_state_nxt = HAZARD;
            w_phase_nxt = PHASE_ON;
          end else if (left) begin
            w_state_nxt = LEFT;
            w_step_nxt  = STEP_ONE;
          end else if (right) begin
            w_state_nxt = RIGHT;
            w_step_nxt  = STEP_ONE;
          end
        end
        LEFT, RIGHT: begin
          if (hazard) begin
            w_state_nxt = HAZARD;
            w_phase_nxt = PHASE_ON;
            w_step_nxt  = '0;
          end else if (r_step < STEP_MAX) begin
            w_step_nxt  = r_step + STEP_ONE;
          end else begin
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
          end
        end
        HAZARD: begin
          // Leave only after a full-on frame so the flash never ends half-way.
          if ((r_phase == PHASE_ON) && !hazard) begin
            w_state_nxt = IDLE;
            w_phase_nxt = PHASE_OFF;
          end else begin
            w_phase_nxt = ~r_phase;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_step_nxt  = '0;
          w_phase_nxt = PHASE_OFF;
        end
      endcase
    end
  end

  // Per-bit compare keeps the thermometer free of a 1<<N_LAMPS overflow.
  always_comb begin
    w_therm = '0;
    for (int i = 0; i < N_LAMPS; i++) begin
      w_therm[i] = (i < int'(r_step));
    end
  end

  always_comb begin
    w_brk_vec = {N_LAMPS{r_brake_q}};
    lamps_l   = w_brk_vec;
    lamps_r   = w_brk_vec;
    case (r_state)
      LEFT:    lamps_l = w_therm;
      RIGHT:   lamps_r = w_therm;
      HAZARD: begin
        lamps_l = {N_LAMPS{r_phase == PHASE_ON}};
        lamps_r = {N_LAMPS{r_phase == PHASE_ON}};
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_tail_lamp_sequencer.sv
// Bench for tail_lamp_sequencer: vector table, hand-written corner sequences, then random
// stimulus compared each clk against a frame-queue reference model.
module tb_tail_lamp_sequencer;

  localparam int N    = 3;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic reset;
  logic left, right, hazard, brake;
  logic [N-1:0] lamps_l, lamps_r;
  logic busy;

  logic l1, busy1;
  logic [0:0] lamps_l1, lamps_r1;
  logic l8, busy8;
  logic [7:0] lamps_l8, lamps_r8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tail_lamp_sequencer #(.N_LAMPS(N), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .lamps_l(lamps_l), .lamps_r(lamps_r), .busy(busy)
  );

  tail_lamp_sequencer #(.N_LAMPS(1), .TICK_DIV(1)) dut_n1 (
    .clk(clk), .reset(reset), .left(l1), .right(1'b0), .hazard(1'b0), .brake(1'b0),
    .lamps_l(lamps_l1), .lamps_r(lamps_r1), .busy(busy1)
  );

  tail_lamp_sequencer #(.N_LAMPS(8), .TICK_DIV(2)) dut_n8 (
    .clk(clk), .reset(reset), .left(l8), .right(1'b0), .hazard(1'b0), .brake(1'b0),
    .lamps_l(lamps_l8), .lamps_r(lamps_r8), .busy(busy8)
  );

  // Reference model: an active sweep is a queue of lit-lamp counts still to show.
  int  n_edges;
  bit  m_sw, m_left, m_hz, m_hz_lit, m_brk;
  int  m_lit;
  int  m_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n_edges = 0; m_sw = 0; m_left = 0; m_hz = 0; m_hz_lit = 0; m_brk = 0; m_lit = 0;
      m_q.delete();
    end else begin
      if (n_edges % TDIV == TDIV - 1) begin
        if (m_hz) begin
          if (m_hz_lit && !hazard) m_hz = 0;
          else m_hz_lit = !m_hz_lit;
        end else if (m_sw) begin
          if (hazard) begin
            m_sw = 0; m_hz = 1; m_hz_lit = 1; m_q.delete();
          end else if (m_q.size() == 0) begin
            m_sw = 0;
          end else begin
            m_lit = m_q.pop_front();
          end
        end else if (hazard || (left && right)) begin
          m_hz = 1; m_hz_lit = 1;
        end else if (left || right) begin
          m_sw = 1; m_left = left; m_lit = 1;
          m_q.delete();
          for (int k = 2; k <= N; k++) m_q.push_back(k);
        end
      end
      m_brk = brake;
      n_edges++;
    end
  end

  function automatic logic [N-1:0] mdl_side(input bit is_left);
    logic [N-1:0] full;
    full = '1;
    if (m_hz) return m_hz_lit ? full : '0;
    if (m_sw && (m_left == is_left)) return N'((1 << m_lit) - 1);
    return m_brk ? full : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns at the negedge just after the next tick edge of a divider of period t.
  task automatic wait_tick(input int t);
    while ((n_edges % t) != t - 1) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply_tick(input logic l, input logic r, input logic h, input logic b);
    @(negedge clk);
    left = l; right = r; hazard = h; brake = b;
    wait_tick(TDIV);
  endtask

  typedef struct {
    logic l, r, h, b;
    logic [N-1:0] el, er;
    logic eb;
  } vec_t;

  vec_t vecs[15];
  int   hold;

  initial begin
    vecs[0]  = '{1,0,0,0, 3'b001,3'b000,1};
    vecs[1]  = '{0,0,0,0, 3'b011,3'b000,1};
    vecs[2]  = '{0,0,0,0, 3'b111,3'b000,1};
    vecs[3]  = '{0,0,0,0, 3'b000,3'b000,0};
    vecs[4]  = '{0,1,0,1, 3'b111,3'b001,1};
    vecs[5]  = '{0,0,0,1, 3'b111,3'b011,1};
    vecs[6]  = '{0,0,0,1, 3'b111,3'b111,1};
    vecs[7]  = '{0,0,0,1, 3'b111,3'b111,0};
    vecs[8]  = '{1,1,0,0, 3'b111,3'b111,1};
    vecs[9]  = '{0,0,0,0, 3'b000,3'b000,0};
    vecs[10] = '{0,0,1,0, 3'b111,3'b111,1};
    vecs[11] = '{0,0,1,0, 3'b000,3'b000,1};
    vecs[12] = '{0,0,1,1, 3'b111,3'b111,1};
    vecs[13] = '{0,0,0,1, 3'b111,3'b111,0};
    vecs[14] = '{0,0,0,0, 3'b000,3'b000,0};

    reset = 1'b1; left = 0; right = 0; hazard = 0; brake = 0; l1 = 0; l8 = 0;
    #23;
    chk("reset_lamps_l", 32'(lamps_l), 0);
    chk("reset_lamps_r", 32'(lamps_r), 0);
    chk("reset_busy", 32'(busy), 0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) begin
      apply_tick(vecs[i].l, vecs[i].r, vecs[i].h, vecs[i].b);
      chk($sformatf("vec%0d_lamps_l", i), 32'(lamps_l), 32'(vecs[i].el));
      chk($sformatf("vec%0d_lamps_r", i), 32'(lamps_r), 32'(vecs[i].er));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
    end

    // Hazard preempting a left sweep, dropped during an off frame.
    apply_tick(1,0,0,0); chk("pre_l1", 32'(lamps_l), 32'h1);
    apply_tick(0,0,0,0); chk("pre_l2", 32'(lamps_l), 32'h3);
    apply_tick(0,0,1,0); chk("pre_on_l", 32'(lamps_l), 32'h7); chk("pre_on_r", 32'(lamps_r), 32'h7);
    apply_tick(0,0,1,0); chk("pre_off", 32'(lamps_l), 32'h0); chk("pre_off_busy", 32'(busy), 1);
    apply_tick(0,0,0,0); chk("pre_last_on", 32'(lamps_r), 32'h7);
    apply_tick(0,0,0,0); chk("pre_idle", 32'(lamps_l), 32'h0); chk("pre_idle_busy", 32'(busy), 0);

    // Async reset between clock edges in the middle of a sweep.
    apply_tick(1,0,0,0);
    apply_tick(0,0,0,0); chk("ars_pre", 32'(lamps_l), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("ars_lamps_l", 32'(lamps_l), 0);
    chk("ars_busy", 32'(busy), 0);
    @(negedge clk); left = 1'b1; reset = 1'b0;
    for (int k = 0; k < TDIV - 1; k++) begin
      @(negedge clk); chk($sformatf("ars_no_tick%0d", k), 32'(busy), 0);
    end
    @(negedge clk);
    chk("ars_first_tick_busy", 32'(busy), 1);
    chk("ars_first_tick_l", 32'(lamps_l), 32'h1);
    left = 1'b0;
    for (int k = 0; k < 3; k++) wait_tick(TDIV);
    chk("ars_sweep_done", 32'(busy), 0);

    // Single lamp, step every clk, request held.
    @(negedge clk); l1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("n1_step%0d", k), 32'(lamps_l1), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    l1 = 1'b0;

    // Eight lamps: sweep reaches all-on, then goes dark.
    @(negedge clk); l8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_tick(2);
      l8 = 1'b0;
      chk($sformatf("n8_step%0d", k), 32'(lamps_l8), 32'((1 << k) - 1));
    end
    wait_tick(2);
    chk("n8_dark", 32'(lamps_l8), 0);

    // Randomized stimulus against the reference model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_lamps_l", 32'(lamps_l), 32'(mdl_side(1'b1)));
      chk("rnd_lamps_r", 32'(lamps_r), 32'(mdl_side(1'b0)));
      chk("rnd_busy", 32'(busy), 32'(m_sw || m_hz));
      if (hold == 0) begin
        left   = ($urandom_range(0, 99) < 30);
        right  = ($urandom_range(0, 99) < 30);
        hazard = ($urandom_range(0, 99) < 8);
        brake  = ($urandom_range(0, 99) < 35);
        hold   = $urandom_range(1, 10);
      end else begin
        hold--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
